// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states, field sizes and status decode for imem_loader
// IMEM_LOADER_CSUM_EN adds the CSUM state.
package imem_loader_pkg;

    localparam int LEN_BYTES    = 2;
    localparam int WORD_BYTES   = 4;
    localparam int WORD_COUNT_W = 17;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM = 3'd4,
`endif
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    function automatic logic state_busy(state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA)
`ifdef IMEM_LOADER_CSUM_EN
            || (s == ST_CSUM)
`endif
            ;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction memory write port of imem_loader
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// rtl/imem_loader_byte_assembler.sv - packs little-endian bytes into a word, field length set by last_idx
module byte_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic [1:0]  last_idx,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  idx;
    logic [31:0] pack;

    // The completed word includes the byte arriving this cycle, so the
    // loader can act on a field in the same cycle its last byte lands.
    always_comb begin
        word = pack;
        word[{idx, 3'b000} +: 8] = byte_data;
        word_valid = byte_valid && (idx == last_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx  <= 2'd0;
            pack <= 32'd0;
        end else if (clear) begin
            idx <= 2'd0;
        end else if (byte_valid) begin
            pack <= word;
            idx  <= word_valid ? 2'd0 : idx + 2'd1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a length-prefixed image into instruction memory and releases the core
// IMEM_LOADER_CSUM_EN adds a trailing 32-bit checksum of the written words.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    imem_loader_if.slave            bus,
    output logic                    busy,
    output logic                    core_run,
    output logic                    err,
    output logic [WORD_COUNT_W-1:0] word_count
);
    localparam logic [1:0] LEN_LAST  = 2'(LEN_BYTES - 1);
    localparam logic [1:0] WORD_LAST = 2'(WORD_BYTES - 1);
`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t PAYLOAD_END = ST_CSUM;
`else
    localparam state_t PAYLOAD_END = ST_DONE;
`endif

    state_t                  state;
    logic [15:0]             n_words;
    logic                    accept;
    logic                    load_start;
    logic                    word_valid;
    logic [31:0]             word;
    logic [1:0]              last_idx;
    logic [WORD_COUNT_W-1:0] wc_next;
`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0]             csum;
`endif

    assign busy         = state_busy(state);
    assign bus.in_ready = busy;
    assign accept       = bus.in_valid && busy;
    assign load_start   = start && !busy;
    assign last_idx     = (state == ST_LEN0 || state == ST_LEN1) ? LEN_LAST : WORD_LAST;
    assign wc_next      = word_count + 17'd1;

    byte_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load_start),
        .byte_valid (accept),
        .byte_data  (bus.in_data),
        .last_idx   (last_idx),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            n_words        <= 16'd0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= 32'd0;
            core_run       <= 1'b0;
            err            <= 1'b0;
            word_count     <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum           <= 32'd0;
`endif
        end else begin
            bus.imem_we <= 1'b0;
            if (load_start) begin
                state      <= ST_LEN0;
                core_run   <= 1'b0;
                err        <= 1'b0;
                word_count <= '0;
`ifdef IMEM_LOADER_CSUM_EN
                csum       <= 32'd0;
`endif
            end else begin
                case (state)
                    ST_LEN0: if (accept) state <= ST_LEN1;
                    ST_LEN1: if (word_valid) begin
                        n_words <= word[15:0];
                        if ({16'd0, word[15:0]} > 32'(MAX_WORDS))
                            state <= ST_ERR;
                        else if (word[15:0] == 16'd0)
                            state <= PAYLOAD_END;
                        else
                            state <= ST_DATA;
                    end
                    ST_DATA: if (word_valid) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= BASE_ADDR + {13'd0, word_count, 2'b00};
                        bus.imem_wdata <= word;
                        word_count     <= wc_next;
`ifdef IMEM_LOADER_CSUM_EN
                        csum           <= csum + word;
`endif
                        if (wc_next == {1'b0, n_words}) state <= PAYLOAD_END;
                    end
`ifdef IMEM_LOADER_CSUM_EN
                    ST_CSUM: if (word_valid) state <= (word == csum) ? ST_DONE : ST_ERR;
`endif
                    // Status flags lag entry into DONE/ERR by one cycle.
                    ST_DONE: core_run <= 1'b1;
                    ST_ERR:  err      <= 1'b1;
                    default: state    <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader, also valid with IMEM_LOADER_CSUM_EN
module tb_imem_loader;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, core_run, err;
    logic [16:0] word_count;

    imem_loader_if bus();

    imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bus        (bus),
        .busy       (busy),
        .core_run   (core_run),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] wr_addr_q[$], wr_data_q[$];
    logic [31:0] ma[$], md[$];

    always @(negedge clk) if (bus.imem_we) begin
        wr_addr_q.push_back(bus.imem_addr);
        wr_data_q.push_back(bus.imem_wdata);
    end

    typedef struct {
        logic [7:0]  b[10];
        int          nb;
        int          mode;
        bit          run;
        bit          e;
        int          wc;
        int          nw;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    function automatic vec_t mk(logic [79:0] bb, int nb, int mode, bit run, bit e, int wc, int nw,
                                logic [31:0] d0, logic [31:0] d1);
        vec_t v;
        for (int k = 0; k < 10; k++) v.b[k] = bb[79-8*k -: 8];
        v.nb = nb; v.mode = mode; v.run = run; v.e = e; v.wc = wc; v.nw = nw; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: continuous, 1: valid toggles 1-0-1-0, 2: random gaps
    task automatic send(input string tag, input logic [7:0] s[$], input int mode, output bit ok);
        bit tog = 1'b1;
        ok = 1'b1;
        foreach (s[i]) begin
            int guard = 0;
            bit done = 1'b0;
            while (!done) begin
                bit v;
                case (mode)
                    0:       v = 1'b1;
                    1:       begin v = tog; tog = !tog; end
                    default: v = ($urandom_range(0, 2) != 0);
                endcase
                bus.in_valid = v;
                bus.in_data  = v ? s[i] : 8'($urandom);
                done = v && bus.in_ready;
                step();
                guard++;
                if (!done && guard > 50) begin
                    tests++; fails++;
                    $display("FAIL %s/timeout: byte %0d not accepted after %0d cycles", tag, i, guard);
                    bus.in_valid = 1'b0;
                    ok = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic model(input logic [7:0] s[$], output bit run, output bit e, output int wc);
        int n;
        logic [31:0] w;
`ifdef IMEM_LOADER_CSUM_EN
        logic [31:0] sum = 32'd0;
`endif
        ma.delete(); md.delete();
        run = 1'b0; e = 1'b0; wc = 0;
        n = int'({s[1], s[0]});
        if (n > MAXW) begin
            e = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++) begin
            w = {s[2+4*k+3], s[2+4*k+2], s[2+4*k+1], s[2+4*k]};
            ma.push_back(BASE + 32'(4 * k));
            md.push_back(w);
`ifdef IMEM_LOADER_CSUM_EN
            sum += w;
`endif
        end
        wc = n;
`ifdef IMEM_LOADER_CSUM_EN
        w = {s[2+4*n+3], s[2+4*n+2], s[2+4*n+1], s[2+4*n]};
        run = (w == sum);
        e = !run;
`else
        run = 1'b1;
`endif
    endtask

    task automatic push_word(inout logic [7:0] s[$], input logic [31:0] w);
        for (int k = 0; k < 4; k++) s.push_back(8'(w >> (8 * k)));
    endtask

    task automatic rand_stream(output logic [7:0] s[$], input int n_fixed);
        int n;
        logic [31:0] w;
        logic [31:0] sum = 32'd0;
        s.delete();
        if (n_fixed >= 0) n = n_fixed;
        else n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(MAXW + 1, 65535)) : int'($urandom_range(0, 7));
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (n > MAXW) return;
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            sum += w;
            push_word(s, w);
        end
`ifdef IMEM_LOADER_CSUM_EN
        if ($urandom_range(0, 3) == 0) sum += 32'($urandom_range(1, 255));
        push_word(s, sum);
`endif
    endtask

    task automatic run_load(input string tag, input logic [7:0] s[$], input int mode,
                            input bit xr, input bit xe, input int xwc,
                            input logic [31:0] xa[$], input logic [31:0] xd[$]);
        bit ok;
        wr_addr_q.delete(); wr_data_q.delete();
        // start coincides with a valid byte that must not be taken
        start = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hEE;
        step();
        start = 1'b0; bus.in_valid = 1'b0;
        check({tag, "/wc_clr"}, 32'(word_count), 32'd0);
        check({tag, "/busy"}, 32'(busy), 32'd1);
        check({tag, "/flags_clr"}, {30'd0, core_run, err}, 32'd0);
        send(tag, s, mode, ok);
        if (ok) begin
            check({tag, "/flags_early"}, {30'd0, core_run, err}, 32'd0);
            step();
            check({tag, "/core_run"}, 32'(core_run), 32'(xr));
            check({tag, "/err"}, 32'(err), 32'(xe));
        end
        bus.in_valid = 1'b1; bus.in_data = 8'h5A;
        step(); step();
        check({tag, "/trail_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "/idle"}, 32'(busy), 32'd0);
        bus.in_valid = 1'b0;
        check({tag, "/word_count"}, 32'(word_count), 32'(xwc));
        check({tag, "/n_writes"}, 32'(wr_addr_q.size()), 32'(xa.size()));
        foreach (xa[i]) if (i < wr_addr_q.size()) begin
            check($sformatf("%s/addr%0d", tag, i), wr_addr_q[i], xa[i]);
            check($sformatf("%s/data%0d", tag, i), wr_data_q[i], xd[i]);
        end
    endtask

    vec_t        vt[7];
    logic [7:0]  s[$];
    logic [7:0]  s2[$];
    logic [31:0] xa[$], xd[$];
    logic [31:0] sum;
    bit          xr, xe, ok;
    int          xwc;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n = 1'b0;
        step(); step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("rst/in_ready", 32'(bus.in_ready), 32'd0);
        check("rst/imem_we", 32'(bus.imem_we), 32'd0);
        check("rst/busy", 32'(busy), 32'd0);
        check("rst/core_run", 32'(core_run), 32'd0);
        check("rst/err", 32'(err), 32'd0);
        check("rst/imem_addr", bus.imem_addr, BASE);
        check("rst/imem_wdata", bus.imem_wdata, 32'd0);
        check("rst/word_count", 32'(word_count), 32'd0);

        vt[0] = mk(80'h0200_1300_5000_9300_1000, 10, 0, 1, 0, 2, 2, 32'h0050_0013, 32'h0010_0093);
        vt[1] = mk(80'h0200_1300_5000_9300_1000, 10, 1, 1, 0, 2, 2, 32'h0050_0013, 32'h0010_0093);
        vt[2] = mk(80'hFFFF_0000_0000_0000_0000,  2, 0, 0, 1, 0, 0, 32'h0, 32'h0);
        vt[3] = mk(80'h0000_0000_0000_0000_0000,  2, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        vt[4] = mk(80'h0101_0000_0000_0000_0000,  2, 1, 0, 1, 0, 0, 32'h0, 32'h0);
        vt[5] = mk(80'h0100_7856_3412_0000_0000,  6, 2, 1, 0, 1, 1, 32'h1234_5678, 32'h0);
        vt[6] = mk(80'h0200_1300_5000_9300_1000, 10, 2, 1, 0, 2, 2, 32'h0050_0013, 32'h0010_0093);

        for (int i = 0; i < 7; i++) begin
            s.delete(); xa.delete(); xd.delete();
            for (int k = 0; k < vt[i].nb; k++) s.push_back(vt[i].b[k]);
            sum = 32'd0;
            if (vt[i].nw > 0) begin xa.push_back(BASE);      xd.push_back(vt[i].d0); sum += vt[i].d0; end
            if (vt[i].nw > 1) begin xa.push_back(BASE + 4);  xd.push_back(vt[i].d1); sum += vt[i].d1; end
`ifdef IMEM_LOADER_CSUM_EN
            if (!vt[i].e) push_word(s, sum);
`endif
            run_load($sformatf("vec%0d", i), s, vt[i].mode, vt[i].run, vt[i].e, vt[i].wc, xa, xd);
        end

`ifdef IMEM_LOADER_CSUM_EN
        s.delete();
        for (int k = 0; k < 10; k++) s.push_back(vt[0].b[k]);
        push_word(s, 32'h0050_0013 + 32'h0010_0093 + 32'd1);
        xa.delete(); xd.delete();
        xa.push_back(BASE); xa.push_back(BASE + 4);
        xd.push_back(32'h0050_0013); xd.push_back(32'h0010_0093);
        run_load("csum_bad", s, 0, 1'b0, 1'b1, 2, xa, xd);
`endif

        // reset after one of three payload words
        wr_addr_q.delete(); wr_data_q.delete();
        start = 1'b1; step(); start = 1'b0;
        s = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send("midrst", s, 0, ok);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        check("midrst/busy", 32'(busy), 32'd0);
        check("midrst/in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst/word_count", 32'(word_count), 32'd0);
        check("midrst/imem_addr", bus.imem_addr, BASE);
        check("midrst/flags", {30'd0, core_run, err}, 32'd0);
        check("midrst/n_writes", 32'(wr_addr_q.size()), 32'd1);
        bus.in_valid = 1'b1; bus.in_data = 8'h77;
        step(); step();
        check("midrst/no_accept", 32'(busy), 32'd0);
        bus.in_valid = 1'b0;
        s.delete();
        for (int k = 0; k < 10; k++) s.push_back(vt[0].b[k]);
`ifdef IMEM_LOADER_CSUM_EN
        push_word(s, 32'h0050_0013 + 32'h0010_0093);
`endif
        xa.delete(); xd.delete();
        xa.push_back(BASE); xa.push_back(BASE + 4);
        xd.push_back(32'h0050_0013); xd.push_back(32'h0010_0093);
        run_load("after_rst", s, 0, 1'b1, 1'b0, 2, xa, xd);

        // start while busy must not restart the load
        wr_addr_q.delete(); wr_data_q.delete();
        start = 1'b1; step(); start = 1'b0;
        s2.delete();
        for (int k = 0; k < 6; k++) s2.push_back(s[k]);
        send("busy_start", s2, 0, ok);
        start = 1'b1; step(); start = 1'b0;
        check("busy_start/word_count", 32'(word_count), 32'd1);
        check("busy_start/busy", 32'(busy), 32'd1);
        s2.delete();
        for (int k = 6; k < s.size(); k++) s2.push_back(s[k]);
        send("busy_start", s2, 0, ok);
        step();
        check("busy_start/core_run", 32'(core_run), 32'd1);
        check("busy_start/final_wc", 32'(word_count), 32'd2);
        check("busy_start/n_writes", 32'(wr_addr_q.size()), 32'd2);

        // largest legal image
        rand_stream(s, MAXW);
        model(s, xr, xe, xwc);
        run_load("max_words", s, 0, xr, xe, xwc, ma, md);

        for (int r = 0; r < 25; r++) begin
            rand_stream(s, -1);
            model(s, xr, xe, xwc);
            run_load($sformatf("rnd%0d", r), s, r % 3, xr, xe, xwc, ma, md);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
